// File: rtl/pci_pkg.sv
// Shared definitions for the PCI burst target: bus commands, target FSM states, parity helper.
// No logic of its own; pure declarations.
// Imported by pci_target_burst and pci_tgt_mem.
package pci_pkg;

  localparam logic [3:0] CMD_RD = 4'h6;
  localparam logic [3:0] CMD_WR = 4'h7;

  typedef enum logic [2:0] {IDLE, WAIT, DATA, STOP, TURN} tgt_state_t;

  // Widest {ad, cbe} vector the parity helper accepts; narrower buses are zero-extended.
  localparam int PAR_MAX_W = 160;

  // Even parity across a zero-extended vector; zero padding does not change the result.
  function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/pci_tgt_mem.sv
// Purpose: DEPTH x DATA_W target memory with per-byte write enables.
// Latency: write commits on the clock edge; read data registered, valid one edge after rd_en.
// Backpressure: none; caller gates rd_en/wr_en, rd_dat holds when rd_en is low.
module pci_tgt_mem
  import pci_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int BE_W   = DATA_W / 8,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_dat[b*8 +: 8];
      end
    end
  end

  // Registered read port; cleared by reset so the bus sees zero after an abort.
  always_ff @(posedge clk) begin
    if (rst)        rd_dat <= '0;
    else if (rd_en) rd_dat <= mem[rd_idx];
  end

endmodule

// File: rtl/pci_target_burst.sv
// Purpose: PCI-style burst memory target with window decode, wait states and disconnect (STOP).
// Latency: DEVSEL one edge after the address phase, TRDY after WAIT_STATES more; 1 word per transfer.
// Backpressure: irdy high holds the data phase; target disconnects at window end or MAX_BURST.
// Optional parity (par_in/par_out/par_oe/perr) is built when PCI_TGT_PARITY_EN is defined.
module pci_target_burst
  import pci_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int          WAIT_STATES = 0,
  parameter int          MAX_BURST   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame,
  input  logic                irdy,
  input  logic [DATA_W-1:0]   ad_in,
  input  logic [DATA_W/8-1:0] cbe_in,
  output logic [DATA_W-1:0]   ad_out,
  output logic                ad_oe,
  output logic                devsel_out,
  output logic                trdy_out,
  output logic                stop_out,
  output logic                ctl_oe,
  output logic                busy
`ifdef PCI_TGT_PARITY_EN
  ,
  input  logic                par_in,
  output logic                par_out,
  output logic                par_oe,
  output logic                perr
`endif
);

  localparam int          BE_W    = DATA_W / 8;
  localparam int          IDX_W   = $clog2(DEPTH);
  localparam int          SHIFT   = $clog2(BE_W);
  localparam int          CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [31:0] LIMIT   = BASE_ADDR + 32'(DEPTH * BE_W);
  localparam logic [2:0]  WS_LAST = 3'(WAIT_STATES - 1);

  tgt_state_t       state, state_nxt;
  logic             frame_q;
  logic             is_rd;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] xfer_cnt;
  logic [CNT_W:0]   cnt_inc;
  logic [2:0]       ws_cnt;

  logic [31:0]      addr;
  logic [IDX_W-1:0] addr_idx;
  logic             cmd_ok, hit, xfer, at_limit, idx_end;
  logic             wr_en, rd_en;
  logic [IDX_W-1:0] rd_idx;

  assign addr     = ad_in[31:0];
  assign addr_idx = IDX_W'((addr - BASE_ADDR) >> SHIFT);
  assign cmd_ok   = (cbe_in[3:0] == CMD_RD) || (cbe_in[3:0] == CMD_WR);
  // Falling frame only counts while idle, so mid-access glitches cannot start a second access.
  assign hit      = (state == IDLE) && !frame && frame_q && cmd_ok &&
                    (addr >= BASE_ADDR) && (addr < LIMIT);
  assign xfer     = (state == DATA) && !irdy;
  assign idx_end  = (idx == IDX_W'(DEPTH - 1));
  assign cnt_inc  = {1'b0, xfer_cnt} + 1'b1;
  assign at_limit = idx_end || (cnt_inc == (CNT_W+1)'(MAX_BURST));

  assign wr_en  = xfer && !is_rd && !rst;
  // Prefetch the next word on each read transfer so it is on the bus for the following phase.
  assign rd_en  = (hit && (cbe_in[3:0] == CMD_RD)) || (xfer && is_rd && !idx_end);
  assign rd_idx = hit ? addr_idx : idx + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and bus control outputs; a final phase (frame high) beats a disconnect.
  always_comb begin
    state_nxt  = state;
    ctl_oe     = 1'b0;
    devsel_out = 1'b1;
    trdy_out   = 1'b1;
    stop_out   = 1'b1;
    ad_oe      = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: if (hit) state_nxt = (WAIT_STATES > 0) ? WAIT : DATA;
      WAIT: if (ws_cnt == WS_LAST) state_nxt = DATA;
      DATA: begin
        if (xfer) begin
          if (frame)         state_nxt = TURN;
          else if (at_limit) state_nxt = STOP;
        end
      end
      STOP: if (frame) state_nxt = TURN;
      TURN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE) begin
      ctl_oe = 1'b1;
      busy   = 1'b1;
    end
    if (state inside {WAIT, DATA, STOP}) begin
      devsel_out = 1'b0;
      ad_oe      = is_rd;
    end
    if (state == DATA) trdy_out = 1'b0;
    if (state == STOP) stop_out = 1'b0;
  end

  // Access bookkeeping: start index, direction, wait-state and transfer counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q  <= 1'b1;
      is_rd    <= 1'b0;
      idx      <= '0;
      xfer_cnt <= '0;
      ws_cnt   <= '0;
    end else begin
      frame_q <= frame;
      if (hit) begin
        is_rd    <= (cbe_in[3:0] == CMD_RD);
        idx      <= addr_idx;
        xfer_cnt <= '0;
        ws_cnt   <= '0;
      end else begin
        if (state == WAIT) ws_cnt <= ws_cnt + 3'd1;
        if (xfer) begin
          idx      <= idx_end ? idx : idx + 1'b1;
          xfer_cnt <= cnt_inc[CNT_W-1:0];
        end
      end
    end
  end

  pci_tgt_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_idx (idx),
    .wr_dat (ad_in),
    .wr_be  (cbe_in),
    .rd_en  (rd_en),
    .rd_idx (rd_idx),
    .rd_dat (ad_out)
  );

`ifdef PCI_TGT_PARITY_EN
  logic wr_chk;
  logic wr_par;

  // Parity trails its data phase by one cycle; write errors are sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_out <= 1'b0;
      par_oe  <= 1'b0;
      perr    <= 1'b0;
      wr_chk  <= 1'b0;
      wr_par  <= 1'b0;
    end else begin
      par_out <= calc_parity(PAR_MAX_W'({ad_out, cbe_in}));
      par_oe  <= ad_oe;
      wr_chk  <= wr_en;
      wr_par  <= calc_parity(PAR_MAX_W'({ad_in, cbe_in}));
      if (wr_chk && (par_in != wr_par)) perr <= 1'b1;
    end
  end
`endif

endmodule
